// File: rtl/mining_mem_pkg.sv
// Shared definitions for the mining memory sequencer.
// Holds the controller phase codes, the sequencer's internal FSM
// encoding, the default sizing of the block and a helper that maps a
// freshly entered controller phase onto the FSM state that serves it.
package mining_mem_pkg;

  localparam int ADDR_W_DEF      = 9;
  localparam int DATA_W_DEF      = 32;
  localparam int WRITE_LEN_DEF   = 512;
  localparam int READ_LEN_DEF    = 512;
  localparam int DONE_CYCLES_DEF = 4;

  // Phase code driven by the mining phase controller
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_READ  = 2'b10,
    ST_END   = 2'b11
  } PhaseCode;

  // Internal sequencer states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_RD_REQ    = 3'd2,
    S_RD_VALID  = 3'd3,
    S_RD_ADV    = 3'd4,
    S_DONE_WAIT = 3'd5,
    S_DONE_HOLD = 3'd6
  } FsmState;

  // State that handles a phase the controller has just switched into
  function automatic FsmState entryState(input PhaseCode phase);
    case (phase)
      ST_WRITE: return S_WRITE;
      ST_READ:  return S_RD_REQ;
      ST_END:   return S_DONE_WAIT;
      default:  return S_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mining_ram_sp.sv
// Single-port synchronous RAM, 2**ADDR_W words of DATA_W bits.
// Ports:
//   clk_i    rising-edge clock
//   reset_i  synchronous active-high reset, clears the read register only
//   en_i     port enable (read or write this cycle)
//   we_i     write enable, qualified by en_i
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  registered read data, 1-cycle latency, write-first
// The read register only updates when the port is enabled, so the last
// read word stays on rdata_o while the port is idle.
module mining_ram_sp #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Storage array, kept free of reset so it maps onto block RAM
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem[addr_i] <= wdata_i;
    end
  end

  // Read register; a write returns the new word (write-first)
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= we_i ? wdata_i : mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mining_mem_sequencer.sv
// Memory-side responder to the mining phase controller.
// Buffers a write stream into a RAM, hands words back one at a time
// during the read phase and signals completion of the end phase.
// Ports:
//   clk_i              rising-edge clock
//   reset_i            synchronous active-high reset
//   state_i            controller phase (00 idle, 01 write, 10 read, 11 end)
//   we_i               controller write enable
//   indirizzo_read_i   controller read address
//   data_in_i          write-stream word
//   data_in_valid_i    data_in_i qualifier
//   data_out_o         read word, stable while data_out_valid_o is high
//   data_out_valid_o   data_out_o qualifier
//   data_out_ready_i   consumer accepts data_out_o
//   indirizzo_write_o  next RAM write address
//   fine_scrittura_o   pulse: write phase full, or read advance request
//   fine_lettura_o     pulse: last read word accepted
//   fine_o             pulse: end phase complete
module mining_mem_sequencer
  import mining_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WRITE_LEN   = WRITE_LEN_DEF,
  parameter int READ_LEN    = READ_LEN_DEF,
  parameter int DONE_CYCLES = DONE_CYCLES_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [1:0]        state_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] indirizzo_read_i,
  input  logic [DATA_W-1:0] data_in_i,
  input  logic              data_in_valid_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              data_out_valid_o,
  input  logic              data_out_ready_i,
  output logic [ADDR_W-1:0] indirizzo_write_o,
  output logic              fine_scrittura_o,
  output logic              fine_lettura_o,
  output logic              fine_o
);

  localparam int CNT_W = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] WR_LAST   = ADDR_W'(WRITE_LEN - 1);
  localparam logic [ADDR_W-1:0] RD_LAST   = ADDR_W'(READ_LEN - 1);
  localparam logic [CNT_W-1:0]  DONE_LAST = CNT_W'(DONE_CYCLES - 1);

  FsmState           fsm_q, fsm_d;
  logic [1:0]        prevState_q;
  logic [ADDR_W-1:0] wrAddr_q, wrAddr_d;
  logic [CNT_W-1:0]  doneCnt_q, doneCnt_d;
  logic              advWait_q, advWait_d;
  logic              fineScr_q, fineScr_d;
  logic              fineLet_q, fineLet_d;
  logic              fine_q, fine_d;

  logic              phaseChange;
  logic              writeHit;
  logic              writeLast;
  logic              readIssue;
  logic [ADDR_W-1:0] wrAddrEff;
  logic [ADDR_W-1:0] ramAddr;

  // Any change of the controller phase code restarts the FSM in the
  // state serving the new phase. A write arriving in the same cycle as
  // the switch into 01 is accepted at address 0, so a controller that
  // raises state, we and data together loses no word.
  assign phaseChange = (state_i != prevState_q);
  assign wrAddrEff   = phaseChange ? '0 : wrAddr_q;
  assign writeHit    = (state_i == ST_WRITE) && we_i && data_in_valid_i &&
                       (phaseChange || (fsm_q == S_WRITE));
  assign writeLast   = writeHit && (wrAddrEff == WR_LAST);
  assign readIssue   = (fsm_q == S_RD_REQ) && !phaseChange;

  // State register; reset wins over everything else
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fsm_q       <= S_IDLE;
      prevState_q <= ST_IDLE;
      wrAddr_q    <= '0;
      doneCnt_q   <= '0;
      advWait_q   <= 1'b0;
      fineScr_q   <= 1'b0;
      fineLet_q   <= 1'b0;
      fine_q      <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      prevState_q <= state_i;
      wrAddr_q    <= wrAddr_d;
      doneCnt_q   <= doneCnt_d;
      advWait_q   <= advWait_d;
      fineScr_q   <= fineScr_d;
      fineLet_q   <= fineLet_d;
      fine_q      <= fine_d;
    end
  end

  // Next-state logic. S_RD_ADV lasts two cycles: the advance pulse is
  // on the output during the first, and the second leaves room for the
  // controller's registered address increment before the next read.
  always_comb begin
    fsm_d = fsm_q;
    if (phaseChange) begin
      fsm_d = writeLast ? S_IDLE : entryState(PhaseCode'(state_i));
    end else begin
      case (fsm_q)
        S_WRITE: begin
          if (writeLast) fsm_d = S_IDLE;
        end
        S_RD_REQ: begin
          fsm_d = S_RD_VALID;
        end
        S_RD_VALID: begin
          if (data_out_ready_i) begin
            fsm_d = (indirizzo_read_i == RD_LAST) ? S_IDLE : S_RD_ADV;
          end
        end
        S_RD_ADV: begin
          if (advWait_q) fsm_d = S_RD_REQ;
        end
        S_DONE_WAIT: begin
          if (doneCnt_q == DONE_LAST) fsm_d = S_DONE_HOLD;
        end
        default: fsm_d = fsm_q;
      endcase
    end
  end

  // Output and datapath next values. Pulses are registered so they
  // appear the cycle after the event that causes them.
  always_comb begin
    wrAddr_d  = wrAddr_q;
    doneCnt_d = doneCnt_q;
    advWait_d = 1'b0;
    fineScr_d = 1'b0;
    fineLet_d = 1'b0;
    fine_d    = 1'b0;

    if (phaseChange) begin
      doneCnt_d = '0;
      if (state_i == ST_WRITE) wrAddr_d = '0;
    end

    if (writeHit) begin
      if (writeLast) begin
        wrAddr_d  = '0;
        fineScr_d = 1'b1;
      end else begin
        wrAddr_d = wrAddrEff + 1'b1;
      end
    end

    if (!phaseChange) begin
      case (fsm_q)
        S_RD_VALID: begin
          if (data_out_ready_i) begin
            if (indirizzo_read_i == RD_LAST) fineLet_d = 1'b1;
            else                             fineScr_d = 1'b1;
          end
        end
        S_RD_ADV: begin
          advWait_d = !advWait_q;
        end
        S_DONE_WAIT: begin
          if (doneCnt_q == DONE_LAST) fine_d = 1'b1;
          else                        doneCnt_d = doneCnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Single RAM port: the write address while writing, the controller's
  // read address otherwise
  assign ramAddr = writeHit ? wrAddrEff : indirizzo_read_i;

  mining_ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) uRam (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (writeHit || readIssue),
    .we_i    (writeHit),
    .addr_i  (ramAddr),
    .wdata_i (data_in_i),
    .rdata_o (data_out_o)
  );

  assign data_out_valid_o  = (fsm_q == S_RD_VALID);
  assign indirizzo_write_o = wrAddr_q;
  assign fine_scrittura_o  = fineScr_q;
  assign fine_lettura_o    = fineLet_q;
  assign fine_o            = fine_q;

endmodule

// File: tb/tb_mining_mem_sequencer.sv
// Directed bench for mining_mem_sequencer: write fill, streaming read
// with backpressure, input gating, end phase and reset during a write.
module tb_mining_mem_sequencer;

  localparam int ADDR_W      = 9;
  localparam int DATA_W      = 32;
  localparam int WRITE_LEN   = 512;
  localparam int READ_LEN    = 512;
  localparam int DONE_CYCLES = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        state;
  logic              we;
  logic [ADDR_W-1:0] rdAddr;
  logic [DATA_W-1:0] dataIn;
  logic              dataInValid;
  logic [DATA_W-1:0] dataOut;
  logic              dataOutValid;
  logic              dataOutReady;
  logic [ADDR_W-1:0] wrAddr;
  logic              fineScrittura;
  logic              fineLettura;
  logic              fine;

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  always #5 clk = ~clk;

  mining_mem_sequencer #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WRITE_LEN   (WRITE_LEN),
    .READ_LEN    (READ_LEN),
    .DONE_CYCLES (DONE_CYCLES)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .state_i           (state),
    .we_i              (we),
    .indirizzo_read_i  (rdAddr),
    .data_in_i         (dataIn),
    .data_in_valid_i   (dataInValid),
    .data_out_o        (dataOut),
    .data_out_valid_o  (dataOutValid),
    .data_out_ready_i  (dataOutReady),
    .indirizzo_write_o (wrAddr),
    .fine_scrittura_o  (fineScrittura),
    .fine_lettura_o    (fineLettura),
    .fine_o            (fine)
  );

  // Single comparison point; every check in the bench goes through here
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are looked at 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic applyStimulus(input logic [1:0] st, input logic weV, input logic vld,
                               input logic [DATA_W-1:0] d);
    state       = st;
    we          = weV;
    dataInValid = vld;
    dataIn      = d;
  endtask

  // Wait (bounded) for data_out_valid to rise
  task automatic waitValid(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (dataOutValid) seen = 1'b1;
    end
  endtask

  // Hard stop in case something wedges the main sequence
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  pulses;
    int  pulseAt;
    int  expWord;
    int  lastAccept;
    int  scrPulses;
    int  letPulses;
    int  letData;
    int  early;
    int  otherPulses;
    bit  prevValid;
    bit  incPending;
    bit  bpDone;
    bit  done;
    bit  seen;

    // ---------------- reset state ----------------
    reset        = 1'b1;
    dataOutReady = 1'b0;
    rdAddr       = '0;
    applyStimulus(2'b00, 1'b0, 1'b0, '0);
    tick();
    tick();
    checkOutput("rst_wr_addr", wrAddr, 0);
    checkOutput("rst_data_out", dataOut, 0);
    checkOutput("rst_valid", dataOutValid, 0);
    checkOutput("rst_pulses", {fineScrittura, fineLettura, fine}, 0);
    reset = 1'b0;
    tick();

    // ---------------- write fill, data = index ----------------
    applyStimulus(2'b01, 1'b1, 1'b0, '0);
    tick();
    pulses  = 0;
    pulseAt = -1;
    for (int i = 0; i < WRITE_LEN; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b1, DATA_W'(i));
      tick();
      if (fineScrittura) begin
        pulses++;
        pulseAt = i;
      end
      if (i == 99) checkOutput("wr_addr_after_100", wrAddr, 100);
    end
    applyStimulus(2'b01, 1'b0, 1'b0, '0);
    tick();
    if (fineScrittura) pulses++;
    checkOutput("wr_fill_pulse_count", pulses, 1);
    checkOutput("wr_fill_pulse_pos", pulseAt, WRITE_LEN - 1);
    checkOutput("wr_fill_addr_wrap", wrAddr, 0);

    // ---------------- streaming read with backpressure at word 5 ----------------
    applyStimulus(2'b00, 1'b0, 1'b0, '0);
    tick();
    rdAddr       = '0;
    dataOutReady = 1'b1;
    applyStimulus(2'b10, 1'b0, 1'b0, '0);
    expWord    = 0;
    lastAccept = 0;
    scrPulses  = 0;
    letPulses  = 0;
    letData    = -1;
    prevValid  = 1'b0;
    incPending = 1'b0;
    bpDone     = 1'b0;
    done       = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      tick();
      // controller model: registered increment one cycle after the request
      if (incPending) begin
        rdAddr     = rdAddr + 1'b1;
        incPending = 1'b0;
      end
      if (fineScrittura) begin
        scrPulses++;
        incPending = 1'b1;
      end
      if (fineLettura) begin
        letPulses++;
        letData = int'(dataOut);
        done    = 1'b1;
      end
      if (dataOutValid && !prevValid) begin
        checkOutput("rd_word", dataOut, expWord);
        if (expWord > 0) checkOutput("rd_spacing", cycle - lastAccept, 4);
        expWord++;
        if (expWord == 6 && !bpDone) begin
          dataOutReady = 1'b0;
          for (int k = 0; k < 10; k++) begin
            tick();
            checkOutput("bp_data", dataOut, 5);
            checkOutput("bp_valid", dataOutValid, 1);
            checkOutput("bp_no_pulse", {fineScrittura, fineLettura, fine}, 0);
          end
          dataOutReady = 1'b1;
          bpDone       = 1'b1;
        end
      end
      if (dataOutValid && dataOutReady) lastAccept = cycle;
      prevValid = dataOutValid;
    end
    checkOutput("rd_finished", done, 1);
    checkOutput("rd_word_count", expWord, READ_LEN);
    checkOutput("rd_advance_pulses", scrPulses, READ_LEN - 1);
    checkOutput("rd_last_pulses", letPulses, 1);
    checkOutput("rd_last_data", letData, READ_LEN - 1);
    tick();
    checkOutput("rd_after_last", {fineScrittura, fineLettura, dataOutValid}, 0);

    // ---------------- gating of data_in_valid ----------------
    applyStimulus(2'b00, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(2'b01, 1'b1, 1'b0, '0);
    tick();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b1, DATA_W'(i));
      tick();
    end
    checkOutput("gate_wr_addr_start", wrAddr, 7);
    applyStimulus(2'b01, 1'b0, 1'b1, 32'hBAD0_0001);
    for (int k = 0; k < 5; k++) tick();
    checkOutput("gate_we_low_addr", wrAddr, 7);
    rdAddr       = 9'd7;
    dataOutReady = 1'b1;
    applyStimulus(2'b10, 1'b1, 1'b1, 32'hBAD0_0002);
    waitValid(seen);
    checkOutput("gate_read_seen", seen, 1);
    checkOutput("gate_ram_kept", dataOut, 7);
    checkOutput("gate_rd_state_addr", wrAddr, 7);
    applyStimulus(2'b00, 1'b0, 1'b0, '0);
    tick();
    tick();

    // ---------------- end phase ----------------
    applyStimulus(2'b11, 1'b0, 1'b0, '0);
    pulses      = 0;
    pulseAt     = -1;
    otherPulses = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (fine) begin
        pulses++;
        pulseAt = n;
      end
      if (fineScrittura || fineLettura) otherPulses++;
    end
    checkOutput("end_fine_count", pulses, 1);
    checkOutput("end_fine_pos", pulseAt, DONE_CYCLES + 1);
    checkOutput("end_other_pulses", otherPulses, 0);

    // ---------------- reset in the middle of a write ----------------
    applyStimulus(2'b00, 1'b0, 1'b0, '0);
    tick();
    applyStimulus(2'b01, 1'b1, 1'b0, '0);
    tick();
    for (int i = 0; i < 100; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b1, DATA_W'(1000 + i));
      tick();
    end
    checkOutput("mid_wr_addr", wrAddr, 100);
    applyStimulus(2'b01, 1'b1, 1'b0, '0);
    reset = 1'b1;
    tick();
    checkOutput("mid_rst_wr_addr", wrAddr, 0);
    checkOutput("mid_rst_data_out", dataOut, 0);
    checkOutput("mid_rst_valid", dataOutValid, 0);
    checkOutput("mid_rst_pulses", {fineScrittura, fineLettura, fine}, 0);
    reset = 1'b0;
    tick();
    early  = 0;
    pulses = 0;
    for (int i = 0; i < WRITE_LEN; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b1, DATA_W'(2000 + i));
      tick();
      if (fineScrittura) begin
        if (i < WRITE_LEN - 1) early++;
        else                   pulses++;
      end
    end
    checkOutput("restart_early_pulse", early, 0);
    checkOutput("restart_final_pulse", pulses, 1);
    checkOutput("restart_wr_addr", wrAddr, 0);
    applyStimulus(2'b00, 1'b0, 1'b0, '0);
    tick();
    rdAddr       = 9'd100;
    dataOutReady = 1'b0;
    applyStimulus(2'b10, 1'b0, 1'b0, '0);
    waitValid(seen);
    checkOutput("restart_read_seen", seen, 1);
    checkOutput("restart_read_data", dataOut, 2100);
    applyStimulus(2'b00, 1'b0, 1'b0, '0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mining_mem_sequencer.md
Name: mining_mem_sequencer

Overview:
- Memory-side responder to the mining phase controller. It drives the controller's phase-end handshakes and takes the controller's phase code, write enable and read address.
- Write phase: buffers an incoming word stream into an internal RAM and reports when the RAM is full.
- Read phase: returns words one at a time at the controller-supplied address. Each consumer acceptance is acknowledged back to the controller.
- End phase: signals completion so the controller returns to idle.

Parameters:
- ADDR_W, 9, RAM address width; matches the controller read-address width.
- DATA_W, 32, data word width.
- WRITE_LEN, 512, words per write phase, 1..2**ADDR_W.
- READ_LEN, 512, words per read phase, 1..WRITE_LEN.
- DONE_CYCLES, 4, cycles spent in the end phase before fine pulses, >=1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- state  in  2  controller phase: 00 idle, 01 write, 10 read, 11 end.
- we  in  1  controller write enable; RAM writes require state==01 && we.
- indirizzo_read  in  ADDR_W  controller read address.
- data_in  in  DATA_W  write-stream word.
- data_in_valid  in  1  data_in qualifier, one word per cycle.
- data_out  out  DATA_W  read word, held stable while data_out_valid is high.
- data_out_valid  out  1  data_out qualifier.
- data_out_ready  in  1  consumer accepts data_out.
- indirizzo_write  out  ADDR_W  next RAM write address.
- fine_scrittura  out  1  1-cycle pulse: write phase complete (state 01), or read advance request (state 10).
- fine_lettura  out  1  1-cycle pulse: last read word accepted.
- fine  out  1  1-cycle pulse: end phase complete.

Behaviour:
- Reset:
  - Reset has priority over every other event.
  - All outputs go to 0, including data_out and indirizzo_write.
  - Internal FSM goes to S_IDLE.
- Internal FSM states: S_IDLE, S_WRITE, S_RD_REQ, S_RD_VALID, S_RD_ADV, S_DONE_WAIT, S_DONE_HOLD.
- Entering the write phase:
  - A state transition into 01 from any other code, including 01 seen first after reset, clears indirizzo_write and enters S_WRITE.
- S_WRITE:
  - Each cycle with we && data_in_valid writes data_in at indirizzo_write, then increments indirizzo_write.
  - On the write at address WRITE_LEN-1:
    - indirizzo_write wraps to 0.
    - fine_scrittura pulses on the next cycle.
    - FSM moves to S_IDLE.
  - data_in_valid is ignored when we=0 or state!=01.
- Leaving 01 early: state leaving 01 before WRITE_LEN words returns the FSM to S_IDLE with no pulse. RAM contents are kept.
- Entering the read phase: state transition into 10 enters S_RD_REQ.
- S_RD_REQ:
  - Issues the RAM read at indirizzo_read.
  - Synchronous RAM, 1-cycle latency.
  - Next cycle: S_RD_VALID with data_out_valid=1.
- S_RD_VALID:
  - data_out and data_out_valid hold until data_out_ready.
  - On acceptance, data_out_valid drops the next cycle.
  - If indirizzo_read == READ_LEN-1: fine_lettura pulses, FSM goes to S_IDLE.
  - Otherwise: fine_scrittura pulses, FSM goes to S_RD_ADV.
- S_RD_ADV:
  - Waits one cycle for the controller's registered address increment, then goes to S_RD_REQ.
  - Throughput is 1 word per 4 cycles with ready held high.
- Entering the end phase: state transition into 11 enters S_DONE_WAIT.
- S_DONE_WAIT:
  - Counts DONE_CYCLES cycles, then pulses fine for one cycle.
  - Then goes to S_DONE_HOLD, which emits no further pulse until state leaves 11.
- State 00 or an unexpected code change from any state: go to S_IDLE, drop data_out_valid, emit no pulses.
- Pulses are mutually exclusive; at most one of fine_scrittura, fine_lettura, fine is high per cycle.
- Address arithmetic is modulo 2**ADDR_W. indirizzo_read values >= WRITE_LEN are read without checks.

Decomposition:
- Package mining_mem_pkg:
  - Controller phase codes ST_IDLE=2'b00, ST_WRITE=2'b01, ST_READ=2'b10, ST_END=2'b11.
  - Internal FSM state encoding.
  - Default widths.
- Sub-module mining_ram_sp:
  - Single-port synchronous RAM, 2**ADDR_W x DATA_W, registered read, write-first.
  - Instantiated once.
  - The port mux selects the write address in S_WRITE and the read address otherwise.

Test Plan:
- Write fill:
  - Stimulus: reset, state=01, we=1, data_in_valid=1 for 512 cycles, data_in=index.
  - Required: fine_scrittura high exactly one cycle, the cycle after the 512th write; indirizzo_write=0 after.
- Streaming read:
  - Stimulus: state=10, data_out_ready=1, bench models the controller incrementing indirizzo_read one cycle after each fine_scrittura.
  - Required: data_out sequence 0..511; 511 fine_scrittura pulses; one fine_lettura with data_out=511; 4-cycle word spacing.
- Backpressure:
  - Stimulus: data_out_ready low for 10 cycles at word 5.
  - Required: data_out=5 and data_out_valid=1 stable for all 10 cycles; no pulse until ready.
- End phase:
  - Stimulus: state=11 for 20 cycles.
  - Required: fine high exactly once, DONE_CYCLES=4 cycles after entry; no further pulses.
- Reset mid-write:
  - Stimulus: assert reset after 100 words, then restart the write phase.
  - Required: all outputs 0 the cycle after reset; indirizzo_write restarts at 0; fine_scrittura only after 512 new words.
- Gating:
  - Stimulus: data_in_valid=1 with state=10, or with state=01 and we=0.
  - Required: indirizzo_write unchanged; RAM contents unchanged on a subsequent read.
